// File: rtl/chacha20_param_loader_if.sv
// rtl/chacha20_param_loader_if.sv - parameter-set handshake bundle between loader and consumer
interface chacha20_param_loader_if;
  logic         params_valid;
  logic         params_ready;
  logic [255:0] key;
  logic [95:0]  nonce;
  logic [31:0]  counter;

  modport master (output params_valid, key, nonce, counter, input params_ready);
  modport slave  (input params_valid, key, nonce, counter, output params_ready);
endinterface

// File: rtl/chacha20_param_loader.sv
// rtl/chacha20_param_loader.sv - UART-fed ChaCha20 key/nonce/counter loader; PARAM_CHECKSUM_EN adds a trailing XOR byte
module chacha20_param_loader #(
  parameter int CLK_FREQ     = 50000000,
  parameter int BAUD         = 115200,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    uart_rx,
  output logic                    frame_err,
  output logic                    busy,
  chacha20_param_loader_if.master p
);
  localparam int CLKS_PER_BIT   = CLK_FREQ / BAUD;
  localparam int HALF_BIT       = CLKS_PER_BIT / 2;
  localparam int TIMEOUT_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int BIT_CW         = $clog2(CLKS_PER_BIT + 1);
  localparam int GAP_CW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [5:0] LAST_IDX  = 6'd47;

  // two-flop synchronizer plus one delayed copy for falling-edge detection
  logic rx_meta, rx_sync, rx_prev;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  rx_state_t         rx_state;
  logic [BIT_CW-1:0] bit_tmr;
  logic [2:0]        bit_idx;
  logic [7:0]        rx_shift;
  logic              byte_stb;
  logic              rx_err;

  // 8N1 receiver: mid-bit sampling, glitch rejection on the start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= R_IDLE;
      bit_tmr  <= '0;
      bit_idx  <= '0;
      rx_shift <= '0;
      byte_stb <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      byte_stb <= 1'b0;
      rx_err   <= 1'b0;
      case (rx_state)
        R_IDLE: begin
          bit_tmr <= '0;
          if (rx_prev && !rx_sync) rx_state <= R_START;
        end
        R_START: begin
          if (bit_tmr == BIT_CW'(HALF_BIT - 1)) begin
            bit_tmr  <= '0;
            bit_idx  <= '0;
            rx_state <= rx_sync ? R_IDLE : R_DATA;
          end else begin
            bit_tmr <= bit_tmr + 1'b1;
          end
        end
        R_DATA: begin
          if (bit_tmr == BIT_CW'(CLKS_PER_BIT - 1)) begin
            bit_tmr  <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            bit_idx  <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) rx_state <= R_STOP;
          end else begin
            bit_tmr <= bit_tmr + 1'b1;
          end
        end
        R_STOP: begin
          if (bit_tmr == BIT_CW'(CLKS_PER_BIT - 1)) begin
            bit_tmr  <= '0;
            rx_state <= R_IDLE;
            if (rx_sync) byte_stb <= 1'b1;
            else         rx_err   <= 1'b1;
          end else begin
            bit_tmr <= bit_tmr + 1'b1;
          end
        end
        default: rx_state <= R_IDLE;
      endcase
    end
  end

`ifdef PARAM_CHECKSUM_EN
  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_CHECK, S_PEND} state_t;
  logic [7:0] xsum;
`else
  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_PEND} state_t;
`endif
  state_t            state;
  logic [5:0]        idx;
  logic [383:0]      shadow;
  logic [GAP_CW-1:0] gap;
  logic              commit_q;

  // frame FSM: sync hunt, payload collection, commit and hold until transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      idx            <= '0;
      shadow         <= '0;
      gap            <= '0;
      commit_q       <= 1'b0;
      frame_err      <= 1'b0;
      busy           <= 1'b0;
      p.params_valid <= 1'b0;
      p.key          <= '0;
      p.nonce        <= '0;
      p.counter      <= '0;
`ifdef PARAM_CHECKSUM_EN
      xsum           <= '0;
`endif
    end else begin
      frame_err <= 1'b0;
      commit_q  <= 1'b0;
      if (commit_q) begin
        p.key          <= shadow[383:128];
        p.nonce        <= shadow[127:32];
        p.counter      <= shadow[31:0];
        p.params_valid <= 1'b1;
        state          <= S_PEND;
        busy           <= 1'b0;
        gap            <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (rx_err) begin
              frame_err <= 1'b1;
            end else if (byte_stb && rx_shift == SYNC_BYTE) begin
              state <= S_PAYLOAD;
              busy  <= 1'b1;
              idx   <= '0;
              gap   <= '0;
`ifdef PARAM_CHECKSUM_EN
              xsum  <= '0;
`endif
            end
          end
          S_PAYLOAD: begin
            if (rx_err || gap == GAP_CW'(TIMEOUT_CYCLES)) begin
              frame_err <= 1'b1;
              state     <= S_IDLE;
              busy      <= 1'b0;
            end else if (byte_stb) begin
              gap    <= '0;
              shadow <= {shadow[375:0], rx_shift};
              idx    <= idx + 1'b1;
`ifdef PARAM_CHECKSUM_EN
              xsum   <= xsum ^ rx_shift;
              if (idx == LAST_IDX) state <= S_CHECK;
`else
              if (idx == LAST_IDX) commit_q <= 1'b1;
`endif
            end else begin
              gap <= gap + 1'b1;
            end
          end
`ifdef PARAM_CHECKSUM_EN
          S_CHECK: begin
            if (rx_err || gap == GAP_CW'(TIMEOUT_CYCLES)) begin
              frame_err <= 1'b1;
              state     <= S_IDLE;
              busy      <= 1'b0;
            end else if (byte_stb) begin
              gap <= '0;
              if (rx_shift == xsum) begin
                commit_q <= 1'b1;
              end else begin
                frame_err <= 1'b1;
                state     <= S_IDLE;
                busy      <= 1'b0;
              end
            end else begin
              gap <= gap + 1'b1;
            end
          end
`endif
          S_PEND: begin
            // anything arriving while a set is held is an overrun
            if (byte_stb || rx_err) frame_err <= 1'b1;
            if (p.params_valid && p.params_ready) begin
              p.params_valid <= 1'b0;
              state          <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_chacha20_param_loader.sv
// tb/tb_chacha20_param_loader.sv - self-checking bench for chacha20_param_loader
module tb_chacha20_param_loader;
  localparam int CPB = 10;

  typedef struct {
    int n_garbage;
    int cut_at;
    int bad_at;
    bit retry;
    int exp_commits;
    int exp_errs;
  } vec_t;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic uart_rx = 1'b1;
  logic frame_err;
  logic busy;

  chacha20_param_loader_if pif ();

  chacha20_param_loader #(
    .CLK_FREQ    (1000000),
    .BAUD        (100000),
    .TIMEOUT_BITS(20)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .uart_rx  (uart_rx),
    .frame_err(frame_err),
    .busy     (busy),
    .p        (pif.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [383:0] cur;
  assign cur = {pif.key, pif.nonce, pif.counter};

  // monitor: frame_err pulses, params_valid runs and output stability while valid
  int err_total = 0, rise_total = 0, run_len = 0, last_run = 0, stab_viol = 0;
  logic [383:0] held = '0;
  always @(negedge clk) begin
    if (frame_err === 1'b1) err_total++;
    if (pif.params_valid === 1'b1) begin
      if (run_len == 0) begin
        held = cur;
        rise_total++;
      end else if (cur !== held) begin
        stab_viol++;
      end
      run_len++;
    end else if (run_len != 0) begin
      last_run = run_len;
      run_len  = 0;
    end
  end

  task automatic check(input string name, input logic [383:0] got, input logic [383:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // event stream: 0..255 good byte, 256+b byte with low stop bit, -1 long silence
  int ev[$];
  logic [7:0]   fp [48];
  logic [7:0]   mpay [48];
  logic [383:0] exp_out = '0;

  function automatic logic [7:0] rand_non_sync();
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    if (b == 8'hA5) b = 8'h5A;
    return b;
  endfunction

  task automatic rand_payload();
    for (int i = 0; i < 48; i++) fp[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic push_payload(input int n, input int bad_at, input bit bad_sum);
    logic [7:0] x;
    x = 8'h00;
    ev.push_back(32'hA5);
    for (int i = 0; i < n; i++) begin
      if (i == bad_at) begin
        ev.push_back(256 + int'(fp[i]));
        return;
      end
      ev.push_back(int'(fp[i]));
      x = x ^ fp[i];
    end
`ifdef PARAM_CHECKSUM_EN
    if (n == 48) ev.push_back(int'(bad_sum ? ~x : x));
`else
    if (bad_sum) ev.push_back(int'(~x));
`endif
  endtask

  // reference model: walks the byte stream by the frame rules, updates exp_out on commit
  task automatic predict();
    int st;
    int n;
    logic [7:0] x;
    st = 0;
    n  = 0;
    x  = 8'h00;
    for (int i = 0; i < ev.size(); i++) begin
      int e;
      e = ev[i];
      if (e < 0 || e >= 256) begin
        st = 0;
      end else if (st == 0) begin
        if (e == 32'hA5) begin
          st = 1;
          n  = 0;
          x  = 8'h00;
        end
      end else if (st == 1) begin
        mpay[n] = e[7:0];
        x = x ^ e[7:0];
        n++;
        if (n == 48) begin
`ifdef PARAM_CHECKSUM_EN
          st = 2;
`else
          st = 0;
          for (int k = 0; k < 48; k++) exp_out[383 - 8*k -: 8] = mpay[k];
`endif
        end
      end else begin
        if (e[7:0] == x)
          for (int k = 0; k < 48; k++) exp_out[383 - 8*k -: 8] = mpay[k];
        st = 0;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop_ok;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_ev();
    for (int i = 0; i < ev.size(); i++) begin
      int e;
      e = ev[i];
      if (e < 0)        repeat (300) @(negedge clk);
      else if (e >= 256) send_byte(e[7:0], 1'b0);
      else               send_byte(e[7:0], 1'b1);
    end
    repeat (30) @(negedge clk);
    predict();
    ev.delete();
  endtask

  vec_t vt [6];
  int e0, r0, s0;

  initial begin
    vt[0] = '{n_garbage: 0, cut_at: -1, bad_at: -1, retry: 1'b0, exp_commits: 1, exp_errs: 0};
    vt[1] = '{n_garbage: 3, cut_at: -1, bad_at: -1, retry: 1'b0, exp_commits: 1, exp_errs: 0};
    vt[2] = '{n_garbage: 0, cut_at: 20, bad_at: -1, retry: 1'b1, exp_commits: 1, exp_errs: 1};
    vt[3] = '{n_garbage: 0, cut_at: -1, bad_at: 10, retry: 1'b1, exp_commits: 1, exp_errs: 1};
    vt[4] = '{n_garbage: 2, cut_at: 5,  bad_at: -1, retry: 1'b0, exp_commits: 0, exp_errs: 1};
    vt[5] = '{n_garbage: 0, cut_at: -1, bad_at: 47, retry: 1'b0, exp_commits: 0, exp_errs: 1};

    pif.params_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", 384'(pif.params_valid), 384'(0));
    check("rst_frame_err", 384'(frame_err), 384'(0));
    check("rst_busy", 384'(busy), 384'(0));
    check("rst_outputs", cur, 384'(0));
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // fixed frame with params_ready held high
    for (int i = 0; i < 32; i++) fp[i] = 8'(i);
    for (int i = 32; i < 48; i++) fp[i] = 8'h00;
    fp[35] = 8'h09;
    fp[39] = 8'h4A;
    fp[47] = 8'h01;
    r0 = rise_total;
    push_payload(48, -1, 1'b0);
    run_ev();
    check("fixed_commits", 384'(rise_total - r0), 384'(1));
    check("fixed_valid_len", 384'(last_run), 384'(1));
    check("fixed_key", 384'(pif.key), 384'(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f));
    check("fixed_nonce", 384'(pif.nonce), 384'(96'h000000090000004a00000000));
    check("fixed_counter", 384'(pif.counter), 384'(32'h1));

    // table-driven randomized frames with garbage, timeouts and framing errors
    for (int v = 0; v < 6; v++) begin
      e0 = err_total;
      r0 = rise_total;
      s0 = stab_viol;
      for (int g = 0; g < vt[v].n_garbage; g++) ev.push_back(int'(rand_non_sync()));
      rand_payload();
      if (vt[v].cut_at >= 0) begin
        push_payload(vt[v].cut_at, -1, 1'b0);
        ev.push_back(-1);
      end else begin
        push_payload(48, vt[v].bad_at, 1'b0);
      end
      if (vt[v].retry) begin
        rand_payload();
        push_payload(48, -1, 1'b0);
      end
      run_ev();
      check($sformatf("v%0d_commits", v), 384'(rise_total - r0), 384'(vt[v].exp_commits));
      check($sformatf("v%0d_errs", v), 384'(err_total - e0), 384'(vt[v].exp_errs));
      check($sformatf("v%0d_data", v), cur, exp_out);
      check($sformatf("v%0d_busy", v), 384'(busy), 384'(0));
      check($sformatf("v%0d_valid", v), 384'(pif.params_valid), 384'(0));
      check($sformatf("v%0d_stable", v), 384'(stab_viol - s0), 384'(0));
    end

    // consumer stalls 500 cycles; overrun byte while pending
    pif.params_ready = 1'b0;
    s0 = stab_viol;
    rand_payload();
    push_payload(48, -1, 1'b0);
    run_ev();
    repeat (500) @(negedge clk);
    check("stall_valid_held", 384'(pif.params_valid), 384'(1));
    check("stall_run_500", 384'(run_len >= 500), 384'(1));
    check("stall_data", cur, exp_out);
    e0 = err_total;
    send_byte(rand_non_sync(), 1'b1);
    repeat (20) @(negedge clk);
    check("overrun_err", 384'(err_total - e0), 384'(1));
    check("overrun_valid", 384'(pif.params_valid), 384'(1));
    pif.params_ready = 1'b1;
    @(negedge clk);
    check("stall_drop", 384'(pif.params_valid), 384'(0));
    check("stall_retain", cur, exp_out);
    check("stall_stable", 384'(stab_viol - s0), 384'(0));

    // reset asserted in the middle of payload byte 30
    rand_payload();
    push_payload(30, -1, 1'b0);
    run_ev();
    check("mid_busy", 384'(busy), 384'(1));
    uart_rx = 1'b0;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst_outputs", cur, 384'(0));
    check("async_rst_valid", 384'(pif.params_valid), 384'(0));
    check("async_rst_busy", 384'(busy), 384'(0));
    exp_out = '0;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    r0 = rise_total;
    for (int i = 0; i < 5; i++) ev.push_back(int'(rand_non_sync()));
    rand_payload();
    push_payload(48, -1, 1'b0);
    run_ev();
    check("post_rst_commits", 384'(rise_total - r0), 384'(1));
    check("post_rst_data", cur, exp_out);

`ifdef PARAM_CHECKSUM_EN
    // wrong checksum is rejected, correct one commits
    e0 = err_total;
    r0 = rise_total;
    rand_payload();
    push_payload(48, -1, 1'b1);
    run_ev();
    check("csum_bad_commits", 384'(rise_total - r0), 384'(0));
    check("csum_bad_errs", 384'(err_total - e0), 384'(1));
    check("csum_bad_data", cur, exp_out);
    r0 = rise_total;
    push_payload(48, -1, 1'b0);
    run_ev();
    check("csum_good_commits", 384'(rise_total - r0), 384'(1));
    check("csum_good_data", cur, exp_out);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
